// File: rtl/hr_pkg.sv
// Shared constants and FSM encoding for the RR-interval rhythm classifier.
package hr_pkg;
    localparam int unsigned RR_W      = 12;
    localparam int unsigned WIN_LOG2  = 3;
    localparam int unsigned WIN_DEPTH = 1 << WIN_LOG2;
    localparam int unsigned SUM_W     = RR_W + WIN_LOG2;
    localparam int unsigned FILL_W    = WIN_LOG2 + 1;
    localparam int unsigned MIN_RR_MS = 250;
    localparam int unsigned MAX_RR_MS = 2500;
    localparam int unsigned TACHY_MS  = 600;
    localparam int unsigned BRADY_MS  = 1200;
    localparam int unsigned IRR_SHIFT = 2;
    localparam int unsigned ASYS_MS   = 3000;
    localparam int unsigned ASYS_W    = 12;
    localparam int unsigned IRR_CNT_W = 8;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } cls_state_t;
endpackage

// File: rtl/rr_window_buffer.sv
// Eight-entry circular buffer of accepted RR intervals with a running sum.
module rr_window_buffer
    import hr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [RR_W-1:0]  wr_data,
    output logic [SUM_W-1:0] sum,
    output logic             full
);

    logic [RR_W-1:0]     entries [WIN_DEPTH];
    logic [WIN_LOG2-1:0] wp;
    logic [FILL_W-1:0]   fill;

    // Oldest entry leaves the sum as the new one enters; empty slots hold 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(WIN_DEPTH); i++) entries[i] <= '0;
            sum  <= '0;
            wp   <= '0;
            fill <= '0;
        end else if (wr_en) begin
            sum         <= sum - SUM_W'(entries[wp]) + SUM_W'(wr_data);
            entries[wp] <= wr_data;
            wp          <= wp + 1'b1;
            if (fill != FILL_W'(WIN_DEPTH)) fill <= fill + 1'b1;
        end
    end

    assign full = (fill == FILL_W'(WIN_DEPTH));

endmodule

// File: rtl/rr_rhythm_classifier.sv
// Per-beat rhythm classification over an 8-beat RR window plus an asystole timer.
module rr_rhythm_classifier
    import hr_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_1ms,
    input  logic [RR_W-1:0]      rr_interval_ms,
    input  logic                 new_rr_pulse,
    output logic                 class_valid,
    output logic [RR_W-1:0]      avg_rr_ms,
    output logic                 window_full,
    output logic                 tachy,
    output logic                 brady,
    output logic                 irregular,
    output logic                 artifact,
    output logic                 asystole,
    output logic [IRR_CNT_W-1:0] irr_count
);

    cls_state_t       state, state_next;
    logic             run_c;
    logic [SUM_W-1:0] sum;
    logic             full;
    logic [RR_W-1:0]  avg_pre_c, avg_post_c, dev_c;
    logic             accept_c, irr_c;
    logic             s1_valid, s1_accept, s1_irr;
    logic [ASYS_W-1:0] asys_cnt;

    rr_window_buffer u_window (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept_c),
        .wr_data (rr_interval_ms),
        .sum     (sum),
        .full    (full)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= WARMUP;
        else     state <= state_next;
    end

    // full rises on the 8th accept edge, so run_c covers the cycle before RUN is registered.
    always_comb begin
        state_next = state;
        run_c      = 1'b0;
        case (state)
            WARMUP: begin
                run_c = full;
                if (full) state_next = RUN;
            end
            RUN: run_c = 1'b1;
            default: state_next = WARMUP;
        endcase
    end

    // Stage 1 decode against the pre-update window.
    always_comb begin
        avg_pre_c  = RR_W'(sum >> WIN_LOG2);
        avg_post_c = avg_pre_c;
        accept_c   = new_rr_pulse &&
                     (rr_interval_ms >= RR_W'(MIN_RR_MS)) &&
                     (rr_interval_ms <= RR_W'(MAX_RR_MS));
        dev_c      = (rr_interval_ms >= avg_pre_c) ? (rr_interval_ms - avg_pre_c)
                                                   : (avg_pre_c - rr_interval_ms);
        irr_c      = accept_c && run_c && (dev_c > (avg_pre_c >> IRR_SHIFT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_accept <= 1'b0;
            s1_irr    <= 1'b0;
        end else begin
            s1_valid  <= new_rr_pulse;
            s1_accept <= accept_c;
            s1_irr    <= irr_c;
        end
    end

    // Stage 2: sum now reflects the beat; rejected beats hold rate flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            class_valid <= 1'b0;
            avg_rr_ms   <= '0;
            window_full <= 1'b0;
            tachy       <= 1'b0;
            brady       <= 1'b0;
            irregular   <= 1'b0;
            artifact    <= 1'b0;
            irr_count   <= '0;
        end else begin
            class_valid <= s1_valid;
            if (s1_valid) begin
                avg_rr_ms   <= avg_post_c;
                window_full <= run_c;
                irregular   <= s1_irr;
                artifact    <= !s1_accept;
                if (s1_accept) begin
                    tachy <= run_c && (avg_post_c < RR_W'(TACHY_MS));
                    brady <= run_c && (avg_post_c > RR_W'(BRADY_MS));
                end
                if (s1_irr && (irr_count != '1)) irr_count <= irr_count + 1'b1;
            end
        end
    end

    // An accepted beat outranks a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            asys_cnt <= '0;
            asystole <= 1'b0;
        end else if (accept_c) begin
            asys_cnt <= '0;
            asystole <= 1'b0;
        end else if (tick_1ms && (asys_cnt != ASYS_W'(ASYS_MS))) begin
            asys_cnt <= asys_cnt + 1'b1;
            asystole <= (asys_cnt == ASYS_W'(ASYS_MS - 1));
        end
    end

endmodule

// File: tb/tb_rr_rhythm_classifier.sv
// Directed bench for rr_rhythm_classifier with hand-computed expectations.
module tb_rr_rhythm_classifier;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_1ms;
    logic [11:0] rr_interval_ms;
    logic        new_rr_pulse;
    logic        class_valid;
    logic [11:0] avg_rr_ms;
    logic        window_full, tachy, brady, irregular, artifact, asystole;
    logic [7:0]  irr_count;

    int n_vec  = 0;
    int n_miss = 0;

    rr_rhythm_classifier dut (
        .clk            (clk),
        .rst            (rst),
        .tick_1ms       (tick_1ms),
        .rr_interval_ms (rr_interval_ms),
        .new_rr_pulse   (new_rr_pulse),
        .class_valid    (class_valid),
        .avg_rr_ms      (avg_rr_ms),
        .window_full    (window_full),
        .tachy          (tachy),
        .brady          (brady),
        .irregular      (irregular),
        .artifact       (artifact),
        .asystole       (asystole),
        .irr_count      (irr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Strobe one interval, then sample just after the stage-2 edge.
    task automatic beat(input int rr);
        @(posedge clk);
        #1 rr_interval_ms = 12'(rr);
        new_rr_pulse = 1'b1;
        @(posedge clk);
        #1 new_rr_pulse = 1'b0;
        chk("cv_early", 32'(class_valid), 0);
        @(posedge clk);
        #1 chk("cv", 32'(class_valid), 1);
    endtask

    task automatic ticks(input int n);
        #0 tick_1ms = 1'b1;
        repeat (n) @(posedge clk);
        #1 tick_1ms = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cv"},    32'(class_valid), 0);
        chk({tag, "_avg"},   32'(avg_rr_ms),   0);
        chk({tag, "_full"},  32'(window_full), 0);
        chk({tag, "_tachy"}, 32'(tachy),       0);
        chk({tag, "_brady"}, 32'(brady),       0);
        chk({tag, "_irr"},   32'(irregular),   0);
        chk({tag, "_art"},   32'(artifact),    0);
        chk({tag, "_asys"},  32'(asystole),    0);
        chk({tag, "_cnt"},   32'(irr_count),   0);
    endtask

    initial begin
        rst = 1'b1; tick_1ms = 1'b0; new_rr_pulse = 1'b0; rr_interval_ms = '0;
        do_reset();
        chk_all_zero("rst");

        // Warm-up with 800 ms beats: 7 beats give 5600/8 = 700.
        for (int i = 0; i < 7; i++) beat(800);
        chk("warm_full", 32'(window_full), 0);
        chk("warm_avg",  32'(avg_rr_ms),   700);
        beat(800);
        chk("fill_full",  32'(window_full), 1);
        chk("fill_avg",   32'(avg_rr_ms),   800);
        chk("fill_tachy", 32'(tachy),       0);
        chk("fill_brady", 32'(brady),       0);
        chk("fill_irr",   32'(irregular),   0);
        chk("fill_art",   32'(artifact),    0);

        // Back-to-back strobes each get their own class_valid.
        @(posedge clk);
        #1 rr_interval_ms = 12'd800; new_rr_pulse = 1'b1;
        @(posedge clk);
        #1 chk("b2b_cv0", 32'(class_valid), 0);
        @(posedge clk);
        #1 new_rr_pulse = 1'b0;
        chk("b2b_cv1", 32'(class_valid), 1);
        @(posedge clk);
        #1 chk("b2b_cv2", 32'(class_valid), 1);
        @(posedge clk);
        #1 chk("b2b_cv3", 32'(class_valid), 0);

        // 1100 vs avg 800: dev 300 > 200; new avg 6700/8 = 837.
        beat(1100);
        chk("irr_flag", 32'(irregular), 1);
        chk("irr_cnt",  32'(irr_count), 1);
        chk("irr_avg",  32'(avg_rr_ms), 837);
        beat(837);
        chk("irr_clear", 32'(irregular), 0);

        // Back to 800, then ramp to 500: beats 1-4 irregular, tachy from beat 6.
        for (int i = 0; i < 8; i++) beat(800);
        chk("re800_avg", 32'(avg_rr_ms), 800);
        for (int i = 0; i < 5; i++) beat(500);
        chk("t5_avg",   32'(avg_rr_ms), 612);
        chk("t5_tachy", 32'(tachy),     0);
        beat(500);
        chk("t6_tachy", 32'(tachy), 1);
        beat(500);
        beat(500);
        chk("tachy_avg",   32'(avg_rr_ms), 500);
        chk("tachy_flag",  32'(tachy),     1);
        chk("tachy_brady", 32'(brady),     0);
        chk("tachy_cnt",   32'(irr_count), 5);

        // Ramp to 1300: beats 1-6 irregular; avg 1200 at beat 7 is not brady.
        for (int i = 0; i < 7; i++) beat(1300);
        chk("b7_avg",   32'(avg_rr_ms), 1200);
        chk("b7_brady", 32'(brady),     0);
        beat(1300);
        chk("brady_avg",   32'(avg_rr_ms), 1300);
        chk("brady_flag",  32'(brady),     1);
        chk("brady_tachy", 32'(tachy),     0);
        chk("brady_cnt",   32'(irr_count), 11);

        // Out-of-range intervals are rejected, rate flags held.
        beat(200);
        chk("art200_flag",  32'(artifact),  1);
        chk("art200_avg",   32'(avg_rr_ms), 1300);
        chk("art200_irr",   32'(irregular), 0);
        chk("art200_brady", 32'(brady),     1);
        beat(2600);
        chk("art2600_flag", 32'(artifact),  1);
        chk("art2600_avg",  32'(avg_rr_ms), 1300);

        // Asystole: a rejected beat mid-count must not restart the timer.
        ticks(1500);
        beat(2600);
        chk("asys_art", 32'(artifact), 1);
        ticks(1499);
        chk("asys_2999", 32'(asystole), 0);
        ticks(1);
        chk("asys_3000", 32'(asystole), 1);
        ticks(5);
        chk("asys_sat", 32'(asystole), 1);

        // Accepted beat coincident with a tick: counter restarts at 0.
        @(posedge clk);
        #1 rr_interval_ms = 12'd800; new_rr_pulse = 1'b1; tick_1ms = 1'b1;
        @(posedge clk);
        #1 new_rr_pulse = 1'b0; tick_1ms = 1'b0;
        chk("coin_asys", 32'(asystole), 0);
        @(posedge clk);
        #1 chk("coin_cv", 32'(class_valid), 1);
        chk("coin_cnt", 32'(irr_count), 12);
        ticks(2999);
        chk("coin_2999", 32'(asystole), 0);
        ticks(1);
        chk("coin_3000", 32'(asystole), 1);

        // Reset between stage 1 and stage 2 kills the pending beat.
        do_reset();
        for (int i = 0; i < 4; i++) beat(800);
        chk("pre_rst_avg", 32'(avg_rr_ms), 400);
        @(posedge clk);
        #1 rr_interval_ms = 12'd800; new_rr_pulse = 1'b1;
        @(posedge clk);
        #1 new_rr_pulse = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_all_zero("mid_rst");
        @(posedge clk);
        #1 chk("mid_rst_cv_late", 32'(class_valid), 0);
        for (int i = 0; i < 7; i++) beat(800);
        chk("post_rst_full7", 32'(window_full), 0);
        chk("post_rst_avg7",  32'(avg_rr_ms),   700);
        beat(800);
        chk("post_rst_full8", 32'(window_full), 1);
        chk("post_rst_avg8",  32'(avg_rr_ms),   800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
